// File: rtl/spi_pkg.sv
// Shared SPI definitions used by both the 12-bit transmitter and the receiver.
package spi_pkg;

  localparam int SPI_WORD_W = 12;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LEAD    = 2'd1,
    SHIFT   = 2'd2,
    WAIT_CS = 2'd3
  } rx_state_t;

endpackage

// File: rtl/spi_sync.sv
// Single-bit multi-flop synchroniser with a synchronous, active-high reset value.
module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_r;

  // Shift the asynchronous input through the flop chain
  always_ff @(posedge clk) begin
    if (rst) begin
      chain_r <= {STAGES{RST_VAL}};
    end else begin
      chain_r <= {chain_r[STAGES-2:0], d};
    end
  end

  assign q = chain_r[STAGES-1];

endmodule

// File: rtl/spi_slave_rx.sv
// SPI receiver: synchronises sclk/cs/mosi, deserialises LSB-first frames and
// presents each word on a valid/ready port with frame_err and overrun flags.
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int WIDTH       = SPI_WORD_W,
  parameter int SYNC_STAGES = 2,
  parameter int LEAD_EDGES  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk,
  input  logic             cs,
  input  logic             mosi,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  input  logic             ready,
  output logic             frame_err,
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int LW = (LEAD_EDGES > 0) ? $clog2(LEAD_EDGES + 1) : 1;
  localparam int SW = $clog2(SYNC_STAGES + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(WIDTH - 1);
  localparam logic [LW-1:0] LEAD_LAST = (LEAD_EDGES > 0) ? LW'(LEAD_EDGES - 1) : '0;
  localparam logic [SW-1:0] SETTLE_N  = SW'(SYNC_STAGES);

  logic             sclk_s;
  logic             cs_s;
  logic             mosi_s;
  logic             sclk_prev_r;
  logic             fall_s;
  logic             settled_s;
  logic [SW-1:0]    settle_cnt_r;
  logic [WIDTH-1:0] word_s;

  rx_state_t        state_r;
  logic [WIDTH-1:0] shift_r;
  logic [CW-1:0]    bit_cnt_r;
  logic [LW-1:0]    lead_cnt_r;
  logic [WIDTH-1:0] data_out_r;
  logic             valid_r;
  logic             frame_err_r;
  logic             overrun_r;

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .d(sclk), .q(sclk_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .d(cs), .q(cs_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .d(mosi), .q(mosi_s)
  );

  // Previous synchronised sclk for falling-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_prev_r <= 1'b0;
    end else begin
      sclk_prev_r <= sclk_s;
    end
  end

  // cs_s shows its reset value until the chain refills, so WAIT_CS must not trust it earlier
  always_ff @(posedge clk) begin
    if (rst) begin
      settle_cnt_r <= '0;
    end else if (!settled_s) begin
      settle_cnt_r <= settle_cnt_r + SW'(1);
    end else begin
      settle_cnt_r <= settle_cnt_r;
    end
  end

  assign fall_s    = sclk_prev_r & ~sclk_s;
  assign settled_s = (settle_cnt_r == SETTLE_N);
  assign word_s    = {mosi_s, shift_r[WIDTH-1:1]};

  // Receive FSM with registered word/valid/error outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= WAIT_CS;
      shift_r     <= '0;
      bit_cnt_r   <= '0;
      lead_cnt_r  <= '0;
      data_out_r  <= '0;
      valid_r     <= 1'b0;
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
      if (valid_r && ready) begin
        valid_r <= 1'b0;
      end
      case (state_r)
        IDLE: begin
          if (!cs_s) begin
            lead_cnt_r <= '0;
            bit_cnt_r  <= '0;
            state_r    <= (LEAD_EDGES == 0) ? SHIFT : LEAD;
          end
        end
        LEAD: begin
          if (cs_s) begin
            state_r     <= IDLE;
            frame_err_r <= 1'b1;
          end else if (fall_s) begin
            lead_cnt_r <= lead_cnt_r + LW'(1);
            if (lead_cnt_r == LEAD_LAST) begin
              state_r <= SHIFT;
            end
          end
        end
        SHIFT: begin
          // cs wins over a coincident sclk fall
          if (cs_s) begin
            state_r     <= IDLE;
            frame_err_r <= 1'b1;
          end else if (fall_s) begin
            shift_r   <= word_s;
            bit_cnt_r <= bit_cnt_r + CW'(1);
            if (bit_cnt_r == BIT_LAST) begin
              state_r <= WAIT_CS;
              if (!valid_r || ready) begin
                data_out_r <= word_s;
                valid_r    <= 1'b1;
              end else begin
                overrun_r <= 1'b1;
              end
            end
          end
        end
        WAIT_CS: begin
          if (settled_s && cs_s) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= WAIT_CS;
        end
      endcase
    end
  end

  assign data_out  = data_out_r;
  assign valid     = valid_r;
  assign frame_err = frame_err_r;
  assign overrun   = overrun_r;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: LSB-first frames with one lead edge.
module tb_spi_slave_rx;

  localparam int W    = 12;
  localparam int LEAD = 1;
  localparam int HALF = 10;

  logic         clk = 1'b0;
  logic         rst, sclk, cs, mosi, ready;
  logic [W-1:0] data_out;
  logic         valid, frame_err, overrun;

  int checks = 0;
  int errors = 0;
  int rise_cnt = 0, fe_cnt = 0, ov_cnt = 0;
  logic [W-1:0] rise_word = '0;
  logic valid_q = 1'b0;

  spi_slave_rx #(.WIDTH(W), .SYNC_STAGES(2), .LEAD_EDGES(LEAD)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi),
    .data_out(data_out), .valid(valid), .ready(ready),
    .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Event monitor sampled away from the active edge
  always @(negedge clk) begin
    if (valid && !valid_q) begin
      rise_cnt  = rise_cnt + 1;
      rise_word = data_out;
    end
    if (frame_err) fe_cnt = fe_cnt + 1;
    if (overrun) ov_cnt = ov_cnt + 1;
    valid_q = valid;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // Drive one cs-low window with `edges` sclk pulses; optional mid-frame reset / ready pulse
  task automatic spi_frame(input logic [W-1:0] word, input int edges, input int rst_after,
                           input bit ready_pulse);
    cs = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int e = 0; e < edges; e++) begin
      int idx;
      idx  = e - LEAD;
      mosi = (idx >= 0 && idx < W) ? word[idx] : 1'b1;
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
      if (ready_pulse && e == LEAD + W - 1) begin
        repeat (2) @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        repeat (HALF - 3) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      if (e + 1 == rst_after) begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
      end
    end
    repeat (HALF) @(negedge clk);
    cs = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b0; ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_data_out", 32'(data_out), 32'h0);
    chk("reset_valid", 32'(valid), 32'h0);
    chk("reset_frame_err", 32'(frame_err), 32'h0);
    chk("reset_overrun", 32'(overrun), 32'h0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_basic();
    int r0, f0, o0;
    r0 = rise_cnt; f0 = fe_cnt; o0 = ov_cnt;
    ready = 1'b1;
    spi_frame(12'hA5C, LEAD + W, -1, 1'b0);
    chk("basic_rises", 32'(rise_cnt - r0), 32'd1);
    chk("basic_word", 32'(rise_word), 32'hA5C);
    chk("basic_valid_dropped", 32'(valid), 32'h0);
    chk("basic_frame_err", 32'(fe_cnt - f0), 32'd0);
    chk("basic_overrun", 32'(ov_cnt - o0), 32'd0);
  endtask

  task automatic test_overrun();
    int r0, o0;
    r0 = rise_cnt; o0 = ov_cnt;
    ready = 1'b0;
    spi_frame(12'h123, LEAD + W, -1, 1'b0);
    spi_frame(12'hFFF, LEAD + W, -1, 1'b0);
    chk("ovr_valid_held", 32'(valid), 32'h1);
    chk("ovr_data_held", 32'(data_out), 32'h123);
    chk("ovr_pulses", 32'(ov_cnt - o0), 32'd1);
    chk("ovr_rises", 32'(rise_cnt - r0), 32'd1);
    ready = 1'b1;
    @(negedge clk);
    chk("ovr_consume_valid", 32'(valid), 32'h0);
    chk("ovr_consume_data", 32'(data_out), 32'h123);
  endtask

  task automatic test_truncated();
    int r0, f0;
    r0 = rise_cnt; f0 = fe_cnt;
    ready = 1'b1;
    spi_frame(12'h0F0, LEAD + 5, -1, 1'b0);
    chk("trunc_frame_err", 32'(fe_cnt - f0), 32'd1);
    chk("trunc_valid", 32'(valid), 32'h0);
    chk("trunc_rises", 32'(rise_cnt - r0), 32'd0);
    r0 = rise_cnt;
    spi_frame(12'h801, LEAD + W, -1, 1'b0);
    chk("after_trunc_rises", 32'(rise_cnt - r0), 32'd1);
    chk("after_trunc_word", 32'(rise_word), 32'h801);
  endtask

  task automatic test_midframe_reset();
    int r0, f0;
    ready = 1'b1;
    spi_frame(12'h5A5, LEAD + W, LEAD + 6, 1'b0);
    r0 = rise_cnt; f0 = fe_cnt;
    chk("mrst_data_cleared", 32'(data_out), 32'h0);
    chk("mrst_valid", 32'(valid), 32'h0);
    spi_frame(12'h3C3, LEAD + W, -1, 1'b0);
    chk("mrst_next_rises", 32'(rise_cnt - r0), 32'd1);
    chk("mrst_next_word", 32'(rise_word), 32'h3C3);
    chk("mrst_frame_err", 32'(fe_cnt - f0), 32'd0);
  endtask

  task automatic test_reset_tail();
    int r0, f0;
    r0 = rise_cnt; f0 = fe_cnt;
    ready = 1'b1;
    spi_frame(12'h5A5, LEAD + W, LEAD + 6, 1'b0);
    chk("rst_tail_rises", 32'(rise_cnt - r0), 32'd0);
    chk("rst_tail_frame_err", 32'(fe_cnt - f0), 32'd0);
  endtask

  task automatic test_back_to_back();
    int r0, o0;
    ready = 1'b0;
    spi_frame(12'h111, LEAD + W, -1, 1'b0);
    chk("b2b_first_word", 32'(data_out), 32'h111);
    chk("b2b_first_valid", 32'(valid), 32'h1);
    r0 = rise_cnt; o0 = ov_cnt;
    spi_frame(12'h222, LEAD + W, -1, 1'b1);
    chk("b2b_word", 32'(data_out), 32'h222);
    chk("b2b_valid", 32'(valid), 32'h1);
    chk("b2b_overrun", 32'(ov_cnt - o0), 32'd0);
    chk("b2b_no_new_rise", 32'(rise_cnt - r0), 32'd0);
    ready = 1'b1;
    @(negedge clk);
    chk("b2b_consumed", 32'(valid), 32'h0);
  endtask

  task automatic test_extra_edges();
    int r0, o0, f0;
    r0 = rise_cnt; o0 = ov_cnt; f0 = fe_cnt;
    ready = 1'b1;
    spi_frame(12'hABC, 14, -1, 1'b0);
    chk("extra_rises", 32'(rise_cnt - r0), 32'd1);
    chk("extra_word", 32'(rise_word), 32'hABC);
    chk("extra_data_out", 32'(data_out), 32'hABC);
    chk("extra_overrun", 32'(ov_cnt - o0), 32'd0);
    chk("extra_frame_err", 32'(fe_cnt - f0), 32'd0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_truncated();
    test_reset_tail();
    test_midframe_reset();
    test_back_to_back();
    test_extra_edges();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave_rx.md
Name: spi_slave_rx

Overview:
- Receive-side counterpart of the team's 12-bit SPI master transmitter; sits directly downstream on the sclk/cs/mosi wires.
- Synchronises the three SPI lines into the 100 MHz system domain (sclk ≈ 1 MHz) and detects sclk edges.
- Deserialises LSB-first frames into parallel words and presents each word on a valid/ready output port.
- Flags truncated frames and words dropped because the consumer was not ready.

Parameters:
- WIDTH, 12: bits per frame.
- SYNC_STAGES, 2: flops per synchroniser chain; minimum 2.
- LEAD_EDGES, 1: sclk falling edges discarded after cs falls, before the first data bit.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  reset, synchronous, active-high.
- sclk  in  1  SPI clock, asynchronous to clk; idle low.
- cs  in  1  chip select, active-low, asynchronous.
- mosi  in  1  serial data; the master changes it on sclk rising edges.
- data_out  out  WIDTH  received word, LSB = first bit received.
- valid  out  1  data_out holds an unconsumed word.
- ready  in  1  consumer accepts data_out when valid && ready.
- frame_err  out  1  one-clk pulse: cs rose before WIDTH bits were captured.
- overrun  out  1  one-clk pulse: a completed word was dropped because the holding register was full.

Behaviour:
- Reset (clk edge with rst=1):
  - data_out=0, valid=0, frame_err=0, overrun=0.
  - Synchroniser flops load cs=1, sclk=0, mosi=0; shift register and bit_cnt cleared.
  - FSM goes to WAIT_CS, so a frame already in progress when rst is released is ignored.
- Synchronisation and edge detection:
  - sclk, cs and mosi each pass through a SYNC_STAGES chain; all three share the same delay.
  - fall = sclk_prev & ~sclk_s; there is exactly one fall per sclk falling edge.
  - mosi is sampled from the synchronised value in the cycle fall=1, i.e. mid-bit.
- FSM states: IDLE, LEAD, SHIFT, WAIT_CS.
  - IDLE: cs_s==0 → LEAD with lead_cnt=0, bit_cnt=0.
  - LEAD: on each fall, lead_cnt++. When lead_cnt reaches LEAD_EDGES → SHIFT. If LEAD_EDGES=0, IDLE goes straight to SHIFT.
  - SHIFT: on each fall, shift right with mosi entering the MSB, then bit_cnt++. On the edge that captures bit WIDTH-1, the full word is complete → WAIT_CS.
  - WAIT_CS: extra falls are ignored; cs_s==1 → IDLE.
  - cs_s==1 while in LEAD or SHIFT → IDLE. frame_err pulses for 1 cycle; the partial word is discarded and valid/data_out are unchanged.
  - If cs_s==1 and fall occur in the same cycle in SHIFT, cs wins: the bit is not captured.
- Output register:
  - On the clk edge capturing the last bit: if valid==0 or (valid && ready) that cycle, data_out ← word and valid ← 1.
  - Otherwise the new word is dropped, overrun pulses for 1 cycle, and the old data_out is kept.
  - Completion coinciding with consumption: the new word loads, valid stays 1, no overrun.
  - valid && ready with no completion: valid ← 0 next edge; data_out holds its last value.
  - data_out never changes while valid==1 && ready==0.
- Latency: valid rises on the same clk edge that captures the last bit. That is SYNC_STAGES+1 clks after the physical sclk falling edge.
- Widths: bit_cnt is $clog2(WIDTH+1) bits and never wraps; lead_cnt is $clog2(LEAD_EDGES+1) bits.

Decomposition:
- Shared package spi_pkg:
  - SPI_WORD_W=12, also used by the transmitter.
  - rx_state_t enum {IDLE, LEAD, SHIFT, WAIT_CS}.
- Sub-module spi_sync (parameter STAGES, RST_VAL): single-bit synchroniser with synchronous reset, instantiated three times.

Test Plan:
- Frame 12'hA5C driven LSB-first with 1 lead edge, ready=1 → valid pulses 1 clk, data_out=12'hA5C; no frame_err/overrun.
- Two frames 12'h123 then 12'hFFF, ready=0 throughout → first word held (data_out=12'h123, valid=1); overrun pulses once at the end of frame 2. Raise ready → valid drops the next clk.
- cs rises after 5 bits of 12'h0F0 → frame_err pulses once, valid stays 0. The next full frame 12'h801 is received correctly.
- rst asserted mid-frame (after 6 bits) and released with cs still low → no valid and no frame_err for the rest of that frame. The next frame 12'h3C3 is received.
- valid=1 with 12'h111, ready asserted exactly on the cycle the last bit of 12'h222 is captured → data_out=12'h222, valid stays 1, no overrun.
- 14 falling edges within one cs-low window carrying 12'hABC → extra edges are ignored, data_out=12'hABC, exactly one valid event.
